// File: rtl/vector_mem_responder.sv
// Purpose : accepts one scalar or vector load/store from the core and serializes it into
//           word-wide element requests toward the data cache, gathering load data back.
// Latency : capture -> ISSUE next edge; each element costs >= 2 edges (handshake, response);
//           done shows 1+2N cycles after capture when downstream never stalls (N=0 -> 1 cycle).
// Backpressure: d_req_ready low holds ISSUE with all d_req_* fields stable; core requests
//           are ignored until the responder returns to IDLE.
// Ports   : core side  - mem_vis_enabled/memory_vis_signal/is_vector/data_type/vector_length,
//                        mem_data_addr, mem_write_*_data in; mem_read_*_data, mem_vis_status out.
//           cache side - d_req_valid/ready/write/addr/size/wdata out, d_resp_valid/rdata in.
module vector_mem_responder #(
   parameter int ADDR_WIDTH       = 17,
   parameter int LEN              = 32,
   parameter int VECTOR_SIZE      = 8,
   parameter int ENTRY_INDEX_SIZE = 3
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          mem_vis_enabled,
   input  logic [1:0]                    memory_vis_signal,
   input  logic                          is_vector,
   input  logic [2:0]                    data_type,
   input  logic [ENTRY_INDEX_SIZE:0]     vector_length,
   input  logic [ADDR_WIDTH-1:0]         mem_data_addr,
   input  logic [LEN-1:0]                mem_write_scalar_data,
   input  logic [LEN*VECTOR_SIZE-1:0]    mem_write_vector_data,
   output logic [LEN-1:0]                mem_read_scalar_data,
   output logic [LEN*VECTOR_SIZE-1:0]    mem_read_vector_data,
   output logic [1:0]                    mem_vis_status,
   output logic                          d_req_valid,
   input  logic                          d_req_ready,
   output logic                          d_req_write,
   output logic [ADDR_WIDTH-1:0]         d_req_addr,
   output logic [1:0]                    d_req_size,
   output logic [LEN-1:0]                d_req_wdata,
   input  logic                          d_resp_valid,
   input  logic [LEN-1:0]                d_resp_rdata
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

   localparam logic [ENTRY_INDEX_SIZE:0] VEC_N = (ENTRY_INDEX_SIZE+1)'(VECTOR_SIZE);

   state_t                       state_q, state_d;
   logic [ADDR_WIDTH-1:0]        base_q, base_d;
   logic                         write_q, write_d;
   logic                         vec_q, vec_d;
   logic [1:0]                   size_q, size_d;
   logic [ENTRY_INDEX_SIZE:0]    n_q, n_d;
   logic [ENTRY_INDEX_SIZE:0]    idx_q, idx_d;
   // Scalar store data is parked in slot 0 so one mux serves both access kinds.
   logic [LEN*VECTOR_SIZE-1:0]   wvec_q, wvec_d;
   logic [LEN-1:0]               rd_scalar_q, rd_scalar_d;
   logic [LEN*VECTOR_SIZE-1:0]   rd_vec_q, rd_vec_d;

   logic                         capture;
   logic [ENTRY_INDEX_SIZE:0]    n_cap;
   logic [ENTRY_INDEX_SIZE:0]    idx_nxt;
   logic [ENTRY_INDEX_SIZE-1:0]  slot;
   logic [LEN-1:0]               rd_elem;
   logic [ADDR_WIDTH-1:0]        offs;

   assign capture = mem_vis_enabled && (memory_vis_signal == 2'b01 || memory_vis_signal == 2'b10);
   assign n_cap   = !is_vector ? (ENTRY_INDEX_SIZE+1)'(1)
                  : (vector_length > VEC_N) ? VEC_N : vector_length;
   assign idx_nxt = idx_q + 1'b1;
   assign slot    = idx_q[ENTRY_INDEX_SIZE-1:0];
   // Element stride is 1/2/4 bytes; the sum wraps naturally at ADDR_WIDTH bits.
   assign offs    = ADDR_WIDTH'(idx_q) << size_q;

   always_comb begin
      case (size_q)
         2'b00:   rd_elem = {{(LEN-8){1'b0}}, d_resp_rdata[7:0]};
         2'b01:   rd_elem = {{(LEN-16){1'b0}}, d_resp_rdata[15:0]};
         default: rd_elem = d_resp_rdata;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      base_d      = base_q;
      write_d     = write_q;
      vec_d       = vec_q;
      size_d      = size_q;
      n_d         = n_q;
      idx_d       = idx_q;
      wvec_d      = wvec_q;
      rd_scalar_d = rd_scalar_q;
      rd_vec_d    = rd_vec_q;
      case (state_q)
         S_IDLE: begin
            if (capture) begin
               base_d      = mem_data_addr;
               write_d     = (memory_vis_signal == 2'b10);
               vec_d       = is_vector;
               size_d      = (data_type == 3'b000) ? 2'b00 :
                             (data_type == 3'b001) ? 2'b01 : 2'b10;
               n_d         = n_cap;
               idx_d       = '0;
               wvec_d      = is_vector ? mem_write_vector_data
                                       : {{(LEN*(VECTOR_SIZE-1)){1'b0}}, mem_write_scalar_data};
               rd_scalar_d = '0;
               rd_vec_d    = '0;
               state_d     = (n_cap == '0) ? S_DONE : S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (d_req_ready) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (d_resp_valid) begin
               if (!write_q) begin
                  if (vec_q) rd_vec_d[slot*LEN +: LEN] = rd_elem;
                  else       rd_scalar_d               = rd_elem;
               end
               idx_d   = idx_nxt;
               state_d = (idx_nxt < n_q) ? S_ISSUE : S_DONE;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         base_q      <= '0;
         write_q     <= 1'b0;
         vec_q       <= 1'b0;
         size_q      <= '0;
         n_q         <= '0;
         idx_q       <= '0;
         wvec_q      <= '0;
         rd_scalar_q <= '0;
         rd_vec_q    <= '0;
      end else begin
         state_q     <= state_d;
         base_q      <= base_d;
         write_q     <= write_d;
         vec_q       <= vec_d;
         size_q      <= size_d;
         n_q         <= n_d;
         idx_q       <= idx_d;
         wvec_q      <= wvec_d;
         rd_scalar_q <= rd_scalar_d;
         rd_vec_q    <= rd_vec_d;
      end
   end

   // Request fields are zeroed outside ISSUE so the cache port is quiet when idle.
   assign d_req_valid          = (state_q == S_ISSUE);
   assign d_req_write          = d_req_valid & write_q;
   assign d_req_addr           = d_req_valid ? base_q + offs : '0;
   assign d_req_size           = d_req_valid ? size_q : 2'b00;
   assign d_req_wdata          = (d_req_valid && write_q) ? wvec_q[slot*LEN +: LEN] : '0;
   assign mem_read_scalar_data = rd_scalar_q;
   assign mem_read_vector_data = rd_vec_q;
   assign mem_vis_status       = (state_q == S_IDLE) ? 2'b00 :
                                 (state_q == S_DONE) ? 2'b10 : 2'b01;

endmodule

// File: tb/tb_vector_mem_responder.sv
module tb_vector_mem_responder;
   localparam int AW  = 17;
   localparam int LEN = 32;
   localparam int VS  = 8;
   localparam int EIS = 3;

   logic              clk;
   logic              rst;
   logic              mem_vis_enabled;
   logic [1:0]        memory_vis_signal;
   logic              is_vector;
   logic [2:0]        data_type;
   logic [EIS:0]      vector_length;
   logic [AW-1:0]     mem_data_addr;
   logic [LEN-1:0]    mem_write_scalar_data;
   logic [LEN*VS-1:0] mem_write_vector_data;
   logic [LEN-1:0]    mem_read_scalar_data;
   logic [LEN*VS-1:0] mem_read_vector_data;
   logic [1:0]        mem_vis_status;
   logic              d_req_valid;
   logic              d_req_ready;
   logic              d_req_write;
   logic [AW-1:0]     d_req_addr;
   logic [1:0]        d_req_size;
   logic [LEN-1:0]    d_req_wdata;
   logic              d_resp_valid;
   logic [LEN-1:0]    d_resp_rdata;

   vector_mem_responder #(.ADDR_WIDTH(AW), .LEN(LEN), .VECTOR_SIZE(VS), .ENTRY_INDEX_SIZE(EIS)) dut (
      .clk(clk), .rst(rst),
      .mem_vis_enabled(mem_vis_enabled), .memory_vis_signal(memory_vis_signal),
      .is_vector(is_vector), .data_type(data_type), .vector_length(vector_length),
      .mem_data_addr(mem_data_addr), .mem_write_scalar_data(mem_write_scalar_data),
      .mem_write_vector_data(mem_write_vector_data),
      .mem_read_scalar_data(mem_read_scalar_data), .mem_read_vector_data(mem_read_vector_data),
      .mem_vis_status(mem_vis_status),
      .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_write(d_req_write),
      .d_req_addr(d_req_addr), .d_req_size(d_req_size), .d_req_wdata(d_req_wdata),
      .d_resp_valid(d_resp_valid), .d_resp_rdata(d_resp_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [AW-1:0]  addr;
      logic           write;
      logic [1:0]     size;
      logic [LEN-1:0] wdata;
   } req_t;

   req_t           exp_req_q[$];
   logic [LEN-1:0] rdata_q[$];
   int             checks = 0;
   int             errors = 0;
   bit             resp_en = 1'b1;
   bit             inject  = 1'b0;

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [LEN-1:0] size_mask(input logic [1:0] sz);
      if (sz == 2'b00)      return 32'h0000_00FF;
      else if (sz == 2'b01) return 32'h0000_FFFF;
      else                  return 32'hFFFF_FFFF;
   endfunction

   // One clock: score any handshake about to happen, then model the cache which
   // answers in the first WAIT cycle after an accepted request.
   task automatic tick();
      req_t e;
      bit   hs;
      bit   hs_write;
      hs       = (d_req_valid === 1'b1) && (d_req_ready === 1'b1) && (rst === 1'b1);
      hs_write = d_req_write;
      if (hs) begin
         checks++;
         assert (exp_req_q.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_req: observed addr=%0h write=%0b expected no request",
                   d_req_addr, d_req_write);
         end
         if (exp_req_q.size() != 0) begin
            e = exp_req_q.pop_front();
            check("req_addr",  d_req_addr,  e.addr);
            check("req_write", d_req_write, e.write);
            check("req_size",  d_req_size,  e.size);
            if (e.write) check("req_wdata", d_req_wdata & size_mask(e.size), e.wdata & size_mask(e.size));
         end
      end
      @(posedge clk);
      @(negedge clk);
      d_resp_valid = inject;
      d_resp_rdata = $urandom;
      if (hs && resp_en) begin
         d_resp_valid = 1'b1;
         if (!hs_write && rdata_q.size() != 0) d_resp_rdata = rdata_q.pop_front();
      end
   endtask

   task automatic start_req(input logic [1:0] sig, input logic vec, input logic [2:0] dt,
                            input logic [EIS:0] vl, input logic [AW-1:0] addr,
                            input logic [LEN-1:0] sd, input logic [LEN*VS-1:0] vd);
      mem_vis_enabled       = 1'b1;
      memory_vis_signal     = sig;
      is_vector             = vec;
      data_type             = dt;
      vector_length         = vl;
      mem_data_addr         = addr;
      mem_write_scalar_data = sd;
      mem_write_vector_data = vd;
      tick();
      mem_vis_enabled       = 1'b0;
   endtask

   // Counts edges after the capture edge until done; done must then last one cycle.
   task automatic wait_done(input string tag, input int exp_edges);
      int edges;
      edges = 0;
      while (mem_vis_status !== 2'b10 && edges < 100) begin
         tick();
         edges++;
      end
      check({tag, "_latency"}, edges, exp_edges);
      check({tag, "_status_done"}, mem_vis_status, 2'b10);
      tick();
      check({tag, "_status_idle"}, mem_vis_status, 2'b00);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [LEN*VS-1:0] vd;
      logic [LEN*VS-1:0] exp_vec;
      logic [LEN-1:0]    rv;

      rst = 1'b0; mem_vis_enabled = 1'b0; memory_vis_signal = 2'b00; is_vector = 1'b0;
      data_type = 3'b000; vector_length = '0; mem_data_addr = '0; mem_write_scalar_data = '0;
      mem_write_vector_data = '0; d_req_ready = 1'b1; d_resp_valid = 1'b0; d_resp_rdata = '0;
      #1;
      check("reset_status", mem_vis_status, 2'b00);
      check("reset_valid", d_req_valid, 1'b0);
      check("reset_scalar", mem_read_scalar_data, '0);
      check("reset_vector", mem_read_vector_data, '0);
      @(negedge clk); @(negedge clk);
      rst = 1'b1;
      tick();

      // Scalar word load.
      exp_req_q.push_back('{addr: 17'h00100, write: 1'b0, size: 2'b10, wdata: '0});
      rdata_q.push_back(32'hDEAD_BEEF);
      start_req(2'b01, 1'b0, 3'b010, '0, 17'h00100, '0, '0);
      wait_done("t1", 2);
      check("t1_scalar", mem_read_scalar_data, 32'hDEAD_BEEF);

      // Vector half store, issued in the first IDLE cycle after done.
      vd = '0;
      for (int i = 0; i < VS; i++) vd[i*LEN +: LEN] = 32'hAAAA_0000 | (32'h1111 * (i + 1));
      for (int i = 0; i < 4; i++)
         exp_req_q.push_back('{addr: AW'(17'h00200 + 2*i), write: 1'b1, size: 2'b01,
                               wdata: 32'h1111 * (i + 1)});
      start_req(2'b10, 1'b1, 3'b001, 4'd4, 17'h00200, '0, vd);
      wait_done("t2", 8);
      check("t2_scalar_held", mem_read_scalar_data, 32'h0);

      // Vector byte load with high garbage in the responses.
      for (int i = 0; i < 3; i++)
         exp_req_q.push_back('{addr: AW'(17'h00300 + i), write: 1'b0, size: 2'b00, wdata: '0});
      rdata_q.push_back(32'hFFFF_FFAB);
      rdata_q.push_back(32'h1234_56CD);
      rdata_q.push_back(32'h8000_00EF);
      start_req(2'b01, 1'b1, 3'b000, 4'd3, 17'h00300, '0, '0);
      wait_done("t3", 6);
      exp_vec = '0;
      exp_vec[0*LEN +: LEN] = 32'hAB;
      exp_vec[1*LEN +: LEN] = 32'hCD;
      exp_vec[2*LEN +: LEN] = 32'hEF;
      check("t3_vector", mem_read_vector_data, exp_vec);

      // Zero-length vector: no downstream access, done right after capture.
      start_req(2'b01, 1'b1, 3'b010, 4'd0, 17'h00400, '0, '0);
      check("t4_no_valid", d_req_valid, 1'b0);
      wait_done("t4", 0);
      check("t4_vector_cleared", mem_read_vector_data, '0);

      // Length above VECTOR_SIZE clamps to 8; word addresses wrap past 0x1FFFF.
      exp_vec = '0;
      for (int i = 0; i < VS; i++) begin
         rv = 32'h0101_0101 * (i + 3);
         exp_vec[i*LEN +: LEN] = rv;
         rdata_q.push_back(rv);
         exp_req_q.push_back('{addr: AW'(17'h1FFF0 + 4*i), write: 1'b0, size: 2'b10, wdata: '0});
      end
      start_req(2'b01, 1'b1, 3'b111, 4'd12, 17'h1FFF0, '0, '0);
      wait_done("t5", 16);
      check("t5_vector", mem_read_vector_data, exp_vec);

      // Stall in ISSUE for 5 cycles; a request pulse while busy must be ignored.
      d_req_ready = 1'b0;
      exp_req_q.push_back('{addr: 17'h00444, write: 1'b1, size: 2'b10, wdata: 32'hCAFE_F00D});
      start_req(2'b10, 1'b0, 3'b010, '0, 17'h00444, 32'hCAFE_F00D, '0);
      for (int i = 0; i < 5; i++) begin
         check("t6_stall_valid", d_req_valid, 1'b1);
         check("t6_stall_addr", d_req_addr, 17'h00444);
         check("t6_stall_wdata", d_req_wdata, 32'hCAFE_F00D);
         if (i == 2) begin
            mem_vis_enabled = 1'b1; memory_vis_signal = 2'b01; mem_data_addr = 17'h00777;
         end else begin
            mem_vis_enabled = 1'b0;
         end
         tick();
      end
      mem_vis_enabled = 1'b0;
      d_req_ready = 1'b1;
      wait_done("t6", 2);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("t6_no_second_access", d_req_valid, 1'b0);
      end
      check("t6_queue_drained", exp_req_q.size(), 0);

      // Reset while waiting for a response; the late response must be dropped.
      resp_en = 1'b0;
      exp_req_q.push_back('{addr: 17'h00500, write: 1'b0, size: 2'b10, wdata: '0});
      start_req(2'b01, 1'b0, 3'b010, '0, 17'h00500, '0, '0);
      tick();
      check("t7_in_wait", mem_vis_status, 2'b01);
      check("t7_prev_vector_kept", mem_read_vector_data, '0);
      #2 rst = 1'b0;
      #1;
      check("t7_rst_status", mem_vis_status, 2'b00);
      check("t7_rst_valid", d_req_valid, 1'b0);
      check("t7_rst_addr", d_req_addr, '0);
      check("t7_rst_scalar", mem_read_scalar_data, '0);
      @(negedge clk);
      rst = 1'b1;
      resp_en = 1'b1;
      rdata_q.delete();
      inject = 1'b1;
      tick();
      tick();
      inject = 1'b0;
      tick();
      check("t7_after_status", mem_vis_status, 2'b00);
      check("t7_after_valid", d_req_valid, 1'b0);
      check("t7_after_scalar", mem_read_scalar_data, '0);
      check("t7_after_vector", mem_read_vector_data, '0);

      // Recovery: an ordinary scalar half load still works after the reset.
      exp_req_q.push_back('{addr: 17'h00600, write: 1'b0, size: 2'b01, wdata: '0});
      rdata_q.push_back(32'h5A5A_9876);
      start_req(2'b01, 1'b0, 3'b001, '0, 17'h00600, '0, '0);
      wait_done("t8", 2);
      check("t8_scalar", mem_read_scalar_data, 32'h0000_9876);
      check("final_queue_empty", exp_req_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
